// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back arbiter: ALU > LSU FIFO head > direct LSU, plus a per-register busy scoreboard.
// Optional macro WB_BYPASS_EN: forwards the write-back value to op1/op2 and clears busy bits one edge earlier.
module regfile_wb_ctrl #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned LSU_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iss_valid,
   input  logic            iss_wen,
   input  logic [4:0]      iss_rd,
   input  logic [4:0]      chk_rs1,
   input  logic [4:0]      chk_rs2,
   output logic            chk_busy1,
   output logic            chk_busy2,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            lsu_valid,
   output logic            lsu_ready,
   input  logic [4:0]      lsu_rd,
   input  logic [XLEN-1:0] lsu_data,
   output logic            rf_wen,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2
);

   localparam int unsigned PW = $clog2(LSU_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [4:0]      fifo_rd_q   [LSU_DEPTH];
   logic [4:0]      fifo_rd_d   [LSU_DEPTH];
   logic [XLEN-1:0] fifo_data_q [LSU_DEPTH];
   logic [XLEN-1:0] fifo_data_d [LSU_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            rf_wen_q, rf_wen_d;
   logic [4:0]      rf_rd_q, rf_rd_d;
   logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
   logic [31:0]     busy_q, busy_d;

   logic            lsu_xfer, fifo_empty, push, pop;
   logic            sel_valid;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            clr_en;
   logic [4:0]      clr_rd;

   assign lsu_ready  = (cnt_q != CW'(LSU_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign lsu_xfer   = lsu_valid && lsu_ready;

   always_comb begin
      sel_valid = 1'b0;
      sel_rd    = '0;
      sel_data  = '0;
      pop       = 1'b0;
      push      = 1'b0;
      if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
         push      = lsu_xfer;
      end else if (!fifo_empty) begin
         sel_valid = 1'b1;
         sel_rd    = fifo_rd_q[rd_ptr_q];
         sel_data  = fifo_data_q[rd_ptr_q];
         pop       = 1'b1;
         push      = lsu_xfer;
      end else if (lsu_xfer) begin
         sel_valid = 1'b1;
         sel_rd    = lsu_rd;
         sel_data  = lsu_data;
      end
   end

   always_comb begin
      fifo_rd_d   = fifo_rd_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         fifo_rd_d[wr_ptr_q]   = lsu_rd;
         fifo_data_d[wr_ptr_q] = lsu_data;
         wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
   end

   // rd==0 results are consumed but leave the write port and its last address/data untouched
   always_comb begin
      rf_wen_d   = sel_valid && (sel_rd != '0);
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      if (rf_wen_d) begin
         rf_rd_d    = sel_rd;
         rf_wdata_d = sel_data;
      end
   end

`ifdef WB_BYPASS_EN
   assign clr_en = rf_wen_d;
   assign clr_rd = sel_rd;
   assign op1    = (rf_wen_q && (rf_rd_q == chk_rs1) && (chk_rs1 != '0)) ? rf_wdata_q : rf_rdata1;
   assign op2    = (rf_wen_q && (rf_rd_q == chk_rs2) && (chk_rs2 != '0)) ? rf_wdata_q : rf_rdata2;
`else
   // Clear on the edge after rf_wen, once the regfile holds the new value
   assign clr_en = rf_wen_q;
   assign clr_rd = rf_rd_q;
   assign op1    = rf_rdata1;
   assign op2    = rf_rdata2;
`endif

   always_comb begin
      busy_d = busy_q;
      if (clr_en) begin
         busy_d[clr_rd] = 1'b0;
      end
      if (iss_valid && iss_wen && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign chk_busy1 = (chk_rs1 != '0) && busy_q[chk_rs1];
   assign chk_busy2 = (chk_rs2 != '0) && busy_q[chk_rs2];
   assign rf_wen    = rf_wen_q;
   assign rf_rd     = rf_rd_q;
   assign rf_wdata  = rf_wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_rd_q   <= '{default: '0};
         fifo_data_q <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         rf_wen_q    <= 1'b0;
         rf_rd_q     <= '0;
         rf_wdata_q  <= '0;
         busy_q      <= '0;
      end else begin
         fifo_rd_q   <= fifo_rd_d;
         fifo_data_q <= fifo_data_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         rf_wen_q    <= rf_wen_d;
         rf_rd_q     <= rf_rd_d;
         rf_wdata_q  <= rf_wdata_d;
         busy_q      <= busy_d;
      end
   end

endmodule
